// File: rtl/bcrypt_sched.sv
`default_nettype none
// ============================================================================
// Module   : bcrypt_sched
// Purpose  : EksBlowfish schedule sequencer for the bcrypt core. Walks the
//            salted INIT expand, 2^cost key/salt expand pairs and the 64x3
//            ciphertext encryption, issuing one datapath strobe per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module bcrypt_sched #(
  parameter int ROUNDS   = 16,
  parameter int COST_MIN = 4
) (
  input  logic        en_clk_2,
  input  logic        reset_l,
  input  logic        start,
  input  logic [4:0]  cost,
  input  logic        sbox_wr_ready,
  output logic        rnd_en,
  output logic        salt_xor,
  output logic        p_xor,
  output logic        salt_key_sel,
  output logic [8:0]  psel,
  output logic        sbox_we,
  output logic [9:0]  sbox_wr_addr,
  output logic        ct_load,
  output logic [1:0]  phase,
  output logic        busy,
  output logic        done,
  output logic        err
);

  // Round counter only needs to reach ROUNDS-1.
  localparam int              RW           = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RW-1:0]   C_RND_LAST   = RW'(ROUNDS - 1);
  localparam logic [RW-1:0]   C_RND_ONE    = RW'(1);
  localparam logic [9:0]      C_BLK_P_LAST = 10'd8;    // blocks 0..8 refill the P-array
  localparam logic [9:0]      C_BLK_LAST   = 10'd520;  // 9 P blocks + 512 S-box blocks
  localparam logic [9:0]      C_SBOX_BASE  = 10'd9;
  localparam logic [7:0]      C_CT_LAST    = 8'd191;   // 64 iterations x 3 ciphertext blocks

  localparam logic [1:0] PH_INIT = 2'd0;
  localparam logic [1:0] PH_KEY  = 2'd1;
  localparam logic [1:0] PH_SALT = 2'd2;
  localparam logic [1:0] PH_CT   = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PXOR    = 3'd1,
    S_ENC     = 3'd2,
    S_WRP     = 3'd3,
    S_WRS     = 3'd4,
    S_CTENC   = 3'd5,
    S_CTSHIFT = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t          r_state;
  logic [4:0]      r_cost;
  logic [31:0]     r_loop;
  logic [9:0]      r_blk;
  logic [RW-1:0]   r_rnd;
  logic [7:0]      r_ct;

  logic [31:0]     w_loop_max;
  logic            w_init;

  // Last loop index; cost = 31 gives 0x7FFF_FFFF, so the 32-bit compare never wraps.
  assign w_loop_max = (32'd1 << r_cost) - 32'd1;
  // The salt is folded into L/R only during the INIT expand pass.
  assign w_init     = (phase == PH_INIT);

  // Schedule FSM; every output is registered and describes the state entered on this edge.
  always_ff @(posedge en_clk_2 or negedge reset_l) begin
    if (!reset_l) begin
      r_state      <= S_IDLE;
      r_cost       <= '0;
      r_loop       <= '0;
      r_blk        <= '0;
      r_rnd        <= '0;
      r_ct         <= '0;
      rnd_en       <= 1'b0;
      salt_xor     <= 1'b0;
      p_xor        <= 1'b0;
      salt_key_sel <= 1'b0;
      psel         <= '0;
      sbox_we      <= 1'b0;
      sbox_wr_addr <= '0;
      ct_load      <= 1'b0;
      phase        <= PH_INIT;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      rnd_en       <= 1'b0;
      salt_xor     <= 1'b0;
      p_xor        <= 1'b0;
      salt_key_sel <= 1'b0;
      psel         <= '0;
      sbox_we      <= 1'b0;
      ct_load      <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (cost >= 5'(COST_MIN)) begin
              r_cost       <= cost;
              r_loop       <= '0;
              r_blk        <= '0;
              r_ct         <= '0;
              sbox_wr_addr <= '0;
              phase        <= PH_INIT;
              busy         <= 1'b1;
              p_xor        <= 1'b1;
              r_state      <= S_PXOR;
            end else begin
              err <= 1'b1;
            end
          end
        end

        S_PXOR: begin
          r_rnd    <= '0;
          rnd_en   <= 1'b1;
          salt_xor <= w_init;
          r_state  <= S_ENC;
        end

        S_ENC: begin
          if (r_rnd == C_RND_LAST) begin
            if (r_blk <= C_BLK_P_LAST) begin
              psel    <= 9'd1 << r_blk;
              r_state <= S_WRP;
            end else begin
              sbox_we      <= 1'b1;
              sbox_wr_addr <= (r_blk - C_SBOX_BASE) << 1;
              r_state      <= S_WRS;
            end
          end else begin
            r_rnd  <= r_rnd + C_RND_ONE;
            rnd_en <= 1'b1;
          end
        end

        S_WRP: begin
          r_blk    <= r_blk + 10'd1;
          r_rnd    <= '0;
          rnd_en   <= 1'b1;
          salt_xor <= w_init;
          r_state  <= S_ENC;
        end

        S_WRS: begin
          if (!sbox_wr_ready) begin
            sbox_we <= 1'b1;
          end else if (r_blk != C_BLK_LAST) begin
            r_blk    <= r_blk + 10'd1;
            r_rnd    <= '0;
            rnd_en   <= 1'b1;
            salt_xor <= w_init;
            r_state  <= S_ENC;
          end else begin
            r_blk        <= '0;
            sbox_wr_addr <= '0;
            case (phase)
              PH_INIT: begin
                phase   <= PH_KEY;
                p_xor   <= 1'b1;
                r_state <= S_PXOR;
              end
              PH_KEY: begin
                phase        <= PH_SALT;
                p_xor        <= 1'b1;
                salt_key_sel <= 1'b1;
                r_state      <= S_PXOR;
              end
              default: begin
                if (r_loop == w_loop_max) begin
                  phase   <= PH_CT;
                  r_ct    <= '0;
                  r_rnd   <= '0;
                  rnd_en  <= 1'b1;
                  r_state <= S_CTENC;
                end else begin
                  r_loop  <= r_loop + 32'd1;
                  phase   <= PH_KEY;
                  p_xor   <= 1'b1;
                  r_state <= S_PXOR;
                end
              end
            endcase
          end
        end

        S_CTENC: begin
          if (r_rnd == C_RND_LAST) begin
            ct_load <= 1'b1;
            r_state <= S_CTSHIFT;
          end else begin
            r_rnd  <= r_rnd + C_RND_ONE;
            rnd_en <= 1'b1;
          end
        end

        S_CTSHIFT: begin
          if (r_ct == C_CT_LAST) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_ct    <= r_ct + 8'd1;
            r_rnd   <= '0;
            rnd_en  <= 1'b1;
            r_state <= S_CTENC;
          end
        end

        S_DONE: begin
          busy    <= 1'b0;
          phase   <= PH_INIT;
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/bcrypt_sched.md
# bcrypt_sched

Top-level sequencer for the bcrypt core. It accepts a start request with a cost factor and drives the Feistel/P-array/S-box datapath through every phase of the EksBlowfish schedule:
- initial salted expand
- 2^cost alternating key/salt expand0 passes
- 64-fold encryption of the three ciphertext blocks

It issues per-cycle strobes (round enable, P-array xor, psel, S-box write, ctext load) and reports busy/done/err to the host side.

## Interface
- ROUNDS, 16, Feistel rounds per block encryption (rnd_en cycles per block)
- COST_MIN, 4, smallest accepted cost
- en_clk_2  in  1  clock; all state updates on its rising edge
- reset_l  in  1  reset, asynchronous, active-low
- start  in  1  request; sampled only in IDLE
- cost  in  5  log2 iteration count; latched on accepted start
- sbox_wr_ready  in  1  S-box SRAM can accept a write this cycle
- rnd_en  out  1  datapath performs one Feistel round
- salt_xor  out  1  datapath xors L/R with the current salt half before the round (en_1 equivalent)
- p_xor  out  1  P-array xored with key/salt this cycle
- salt_key_sel  out  1  0 = key, 1 = salt as the p_xor operand
- psel  out  9  one-hot P-pair select for writeback of L/R
- sbox_we  out  1  write L/R into S-box pair at sbox_wr_addr
- sbox_wr_addr  out  10  even S-box word address (0..1022)
- ct_load  out  1  rotate ciphertext registers / reload L,R
- phase  out  2  0 INIT, 1 LOOP_KEY, 2 LOOP_SALT, 3 CTEXT
- busy  out  1  high from accepted start until DONE exits
- done  out  1  one-cycle pulse at completion
- err  out  1  one-cycle pulse on rejected start

## Operation
- Reset: state IDLE, phase 0. All outputs 0. All counters cleared.
- FSM states: IDLE, PXOR, ENC, WRP, WRS, CTENC, CTSHIFT, DONE.
- IDLE:
  - start with COST_MIN ≤ cost ≤ 31 → latch cost, phase = INIT, go to PXOR.
  - start with cost < COST_MIN → err pulse, stay IDLE.
- Expand pass, used by INIT, LOOP_KEY and LOOP_SALT:
  - PXOR (1 cycle): p_xor = 1. salt_key_sel = 1 only in LOOP_SALT.
  - Then 521 blocks. Each block is ENC followed by WRP (blocks 0..8) or WRS (blocks 9..520).
  - ENC: rnd_en for ROUNDS cycles. In INIT only, salt_xor = 1 on the first round cycle of each block.
  - WRP (1 cycle): psel = 1 << k for P-block k.
  - WRS: sbox_we = 1 and sbox_wr_addr = 2·(block − 9). The state holds with sbox_we high until sbox_wr_ready = 1, then advances.
- Loop counter:
  - 32 bits, counts 0..2^cost − 1.
  - After INIT → LOOP_KEY.
  - LOOP_KEY → LOOP_SALT.
  - LOOP_SALT → LOOP_KEY with counter + 1, or → CTEXT when counter = 2^cost − 1.
  - Compare uses the full 32-bit value. cost = 31 must not overflow.
- CTEXT:
  - 64 iterations × 3 blocks.
  - Per block: CTENC (rnd_en for ROUNDS cycles), then CTSHIFT (ct_load = 1, 1 cycle).
  - After block 192 → DONE.
- DONE (1 cycle): done = 1, busy = 0 on next cycle, return to IDLE.
- Strobe exclusivity: at most one of p_xor, rnd_en, psel≠0, sbox_we, ct_load is high in any cycle.

## Timing
- Accepted start at edge 0 → PXOR is cycle 1. busy rises at cycle 1.
- With sbox_wr_ready held 1:
  - Expand pass = 1 + 521·(ROUNDS+1) cycles = 8858 at ROUNDS = 16.
  - CTEXT = 192·(ROUNDS+1) cycles = 3264.
  - Total active cycles = (1 + 2^(cost+1))·8858 + 3264. done is high in the following cycle.
- Each cycle sbox_wr_ready is low during WRS adds exactly one cycle. No other stall source exists.
- start while busy is ignored (no err).
- Reset mid-operation: immediate (asynchronous) return to IDLE. All outputs 0 in the same cycle. No done. Next start begins fresh at INIT.
- sbox_wr_addr is held stable while stalled. It wraps to 0 at the start of each expand pass.
- psel is 0 outside WRP.

## Test plan
- reset_l low mid-LOOP_KEY, then cost = 4 restart:
  - All outputs 0 while reset is low.
  - Restart phase sequence is 0,1,2,1,2,…,3 with 16 LOOP_KEY entries.
- cost = 4, ROUNDS = 16, ready tied 1:
  - done exactly 295578 cycles after the start edge.
  - 33 p_xor pulses, of which 16 have salt_key_sel = 1.
  - 192 ct_load pulses.
- cost = 3 → err pulse one cycle after start; busy stays 0; no strobes.
- Start with cost = 4, ROUNDS = 2 (1 + 521·3 = 1564-cycle passes), and hold sbox_wr_ready low for 5 cycles at WRS address 100 of the INIT pass:
  - sbox_we held 6 cycles at addr 100.
  - Total latency grows by 5.
- In INIT, count salt_xor = 521 and psel walks 0x001 → 0x100. In loop passes, salt_xor = 0.
- Second start pulse during busy and a start coincident with DONE are both ignored. A start one cycle after done is accepted.
